pcileech_tlps128_tx_pktbuf: RTL
===============================

PCILEECH_TLPS128_TX_PKTBUF -- requirements
Module: pcileech_tlps128_tx_pktbuf

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, log2 of buffer depth in 128-bit beats (512 beats).
REQ-002 SHALL have parameter MAX_PKT_BEATS, default 257, beats allowed per packet before truncation (1024-DW payload + header).
REQ-003 SHALL have port clk_pcie, input, 1, sole clock; all logic in this domain.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tlps_in, IfAXIS128.sink, -, mux output stream: tdata 128, tkeepdw 4, tlast, tuser 9, tvalid, tready, has_data.
REQ-006 SHALL have port tlps_out, IfAXIS128.source, -, stream to PCIe core transmit, same signals.
REQ-007 SHALL have port pkt_count, output, DEPTH_LOG2+1, complete packets currently stored.
REQ-008 SHALL have port err_trunc, output, 1, sticky flag: a packet exceeded MAX_PKT_BEATS.
REQ-009 SHALL have port drop_count, output, 16, saturating count of beats discarded after truncation.

Function
REQ-010 SHALL store-and-forward: no beat of a packet is presented on tlps_out until its tlast beat is written.
REQ-011 SHALL drive tlps_in.tready = 1 when at least one free entry exists, counting uncommitted beats as used.
REQ-012 SHALL write {tuser, tlast, tkeepdw, tdata} (142 bits) at the write pointer on tlps_in.tvalid && tlps_in.tready.
REQ-013 SHALL advance the committed write pointer to the speculative write pointer, and increment pkt_count, in the cycle after the tlast beat is written.
REQ-014 SHALL assert tlps_out.has_data = (pkt_count != 0).
REQ-015 SHALL present data through a one-entry output register: tlps_out.tvalid asserts 2 cycles after the tlast write cycle when the buffer was empty.
REQ-016 SHALL hold tlps_out.tdata/tkeepdw/tlast/tuser stable while tlps_out.tvalid && !tlps_out.tready.
REQ-017 SHALL never deassert tlps_out.tvalid between the first and tlast beat of a packet; the next beat is prefetched while the current beat is accepted.
REQ-018 SHALL decrement pkt_count when the tlast beat transfers on tlps_out; commit and pop in the same cycle leave pkt_count unchanged.
REQ-019 SHALL track incoming beats per packet; on beat number MAX_PKT_BEATS without tlast, SHALL force tlast=1 on the stored beat, commit the packet, and set err_trunc.
REQ-020 SHALL, after truncation, hold tready=1 and discard incoming beats up to and including the next tlast, incrementing drop_count per beat, saturating at 0xFFFF.
REQ-021 SHALL use wrap-around pointer arithmetic with one extra MSB: full = (MSBs differ, lower bits equal); empty = (pointers equal).
REQ-022 SHALL ignore tlps_in.tuser[0] for framing; a packet starts with the beat following a tlast, or with the first beat after reset.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear all pointers, pkt_count, the beat counter, discard state, err_trunc, drop_count, and the output register valid bit.
REQ-024 SHALL drive tlps_out.tvalid=0, has_data=0, and tlps_in.tready=0 while rst_n is low; tready SHALL be 1 in the first cycle after release.
REQ-025 SHALL discard, when reset asserts mid-packet, both the uncommitted partial packet and any partially drained packet; RAM contents need not be cleared.

Structure
REQ-026 SHALL take TLPBUF_W (142), the default MAX_PKT_BEATS, and the packed beat typedef from shared package pcileech_tlp_pkg.
REQ-027 SHALL instantiate a single sub-module pcileech_tlpbuf_ram: simple dual-port, 2^DEPTH_LOG2 x TLPBUF_W, 1-cycle registered read, no reset.

Verification
REQ-028 SHALL check: one 3-beat packet into an empty buffer, tready out=1 -> out tvalid exactly 2 cycles after in tlast; 3 beats back-to-back; pkt_count 1->0.
REQ-029 SHALL check: input stalls 5 cycles between beats 1 and 2 -> no out tvalid until tlast is written; the output is then gap-free.
REQ-030 SHALL check: out tready=0 while 512 single-beat packets are sent -> tready falls after 512 beats; pkt_count=512; full drain returns data in order.
REQ-031 SHALL check: 300-beat packet with MAX_PKT_BEATS=257 -> 257 beats stored with tlast forced on beat 257; err_trunc=1; drop_count=43.
REQ-032 SHALL check: tlast commit and out-tlast pop in the same cycle with pkt_count=2 -> pkt_count stays 2.
REQ-033 SHALL check: rst_n pulsed mid-packet during a drain -> outputs clear immediately; a fresh 2-beat packet afterwards passes intact.

Source files
------------

// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP stream definitions: buffered beat layout and packet-size defaults.
package pcileech_tlp_pkg;

    localparam int TLPBUF_W          = 142;
    localparam int TLP_MAX_PKT_BEATS = 257;

    typedef struct packed {
        logic [8:0]   tuser;
        logic         tlast;
        logic [3:0]   tkeepdw;
        logic [127:0] tdata;
    } tlp_beat_t;

    typedef enum logic {
        IN_PASS    = 1'b0,
        IN_DISCARD = 1'b1
    } in_state_t;

endpackage

// File: rtl/IfAXIS128.sv
// 128-bit AXI-Stream TLP link with dword keep and a "packet pending" hint.
interface IfAXIS128;
    logic [127:0] tdata;
    logic [3:0]   tkeepdw;
    logic         tlast;
    logic [8:0]   tuser;
    logic         tvalid;
    logic         tready;
    logic         has_data;

    modport source (output tdata, tkeepdw, tlast, tuser, tvalid, has_data, input tready);
    modport sink   (input tdata, tkeepdw, tlast, tuser, tvalid, has_data, output tready);
endinterface

// File: rtl/pcileech_tlpbuf_ram.sv
// Simple dual-port beat RAM with a registered, enable-gated read port (no reset).
module pcileech_tlpbuf_ram #(
    parameter int AW = 9,
    parameter int W  = 142
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [0:(1<<AW)-1];

    // The read register only changes on rd_en, so it doubles as a stable output holding stage.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/pcileech_tlps128_tx_pktbuf.sv
// Store-and-forward TX packet buffer between the TLP mux and the PCIe core.
// A packet becomes visible on tlps_out only once its tlast beat sits in the RAM.
module pcileech_tlps128_tx_pktbuf
    import pcileech_tlp_pkg::*;
#(
    parameter int DEPTH_LOG2    = 9,
    parameter int MAX_PKT_BEATS = TLP_MAX_PKT_BEATS
) (
    input  logic                clk_pcie,
    input  logic                rst_n,
    IfAXIS128.sink              tlps_in,
    IfAXIS128.source            tlps_out,
    output logic [DEPTH_LOG2:0] pkt_count,
    output logic                err_trunc,
    output logic [15:0]         drop_count
);
    localparam int AW  = DEPTH_LOG2;
    localparam int BCW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(MAX_PKT_BEATS - 1);

    logic [AW:0]    wr_ptr, wr_cmt, rd_addr, rd_ptr;
    logic           out_valid;
    logic [BCW-1:0] beat_cnt;
    in_state_t      in_state;
    logic           full, in_ready, in_hs, wr_en, trunc, beat_end;
    logic           rd_en, out_pop, out_last_pop;
    tlp_beat_t      wr_beat, rd_beat;

    // A beat parked in the output register still owns its slot until it transfers.
    assign rd_ptr   = rd_addr - {{AW{1'b0}}, out_valid};
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = rst_n && ((in_state == IN_DISCARD) || !full);
    assign in_hs    = tlps_in.tvalid && in_ready;
    assign wr_en    = in_hs && (in_state == IN_PASS);
    assign trunc    = wr_en && !tlps_in.tlast && (beat_cnt == LAST_IDX);
    assign beat_end = wr_en && (tlps_in.tlast || trunc);

    assign wr_beat = '{tuser:   tlps_in.tuser,
                       tlast:   tlps_in.tlast | trunc,
                       tkeepdw: tlps_in.tkeepdw,
                       tdata:   tlps_in.tdata};

    // Reads run only inside the committed region; refill whenever the output slot frees up.
    assign out_pop      = out_valid && tlps_out.tready;
    assign rd_en        = (!out_valid || tlps_out.tready) && (rd_addr != wr_cmt);
    assign out_last_pop = out_pop && rd_beat.tlast;

    pcileech_tlpbuf_ram #(.AW(AW), .W(TLPBUF_W)) u_ram (
        .clk     (clk_pcie),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_beat),
        .rd_en   (rd_en),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (rd_beat)
    );

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            pkt_count  <= '0;
            beat_cnt   <= '0;
            in_state   <= IN_PASS;
            err_trunc  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
            if (beat_end) wr_cmt <= wr_ptr + 1'b1;
            if (rd_en)    rd_addr <= rd_addr + 1'b1;

            if (rd_en)        out_valid <= 1'b1;
            else if (out_pop) out_valid <= 1'b0;

            case ({beat_end, out_last_pop})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: ;
            endcase

            if (beat_end)   beat_cnt <= '0;
            else if (wr_en) beat_cnt <= beat_cnt + 1'b1;

            if (trunc) begin
                in_state  <= IN_DISCARD;
                err_trunc <= 1'b1;
            end else if (in_state == IN_DISCARD && in_hs && tlps_in.tlast) begin
                in_state <= IN_PASS;
            end

            if (in_state == IN_DISCARD && in_hs && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    assign tlps_in.tready    = in_ready;
    assign tlps_out.tvalid   = out_valid;
    assign tlps_out.tdata    = rd_beat.tdata;
    assign tlps_out.tkeepdw  = rd_beat.tkeepdw;
    assign tlps_out.tlast    = rd_beat.tlast;
    assign tlps_out.tuser    = rd_beat.tuser;
    assign tlps_out.has_data = (pkt_count != '0);
endmodule
